load_store_unit: RTL and testbench

- Sits between the execute stage and the word-only data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word accesses.
- Performs read-modify-write for sub-word stores, and sign/zero-extends load data.
- Flags misaligned, out-of-range and illegal requests. Uses a valid/ready request and response handshake so the pipeline can stall on multi-cycle stores.

---
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto a word-only memory, with sub-word read-modify-write.
// Define LSU_SUBWORD_EN for byte/halfword support; otherwise only LW/SW are legal.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 11
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        MEM_WE,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD
);
  typedef enum logic [1:0] {IDLE, RESP `ifdef LSU_SUBWORD_EN , RMW_WR `endif} state_t;
  state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;
`ifdef LSU_SUBWORD_EN
  logic [31:0] old_q, old_d, mask;
  logic [29:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0] off_q, off_d;
  logic half_q, half_d;
`endif
  logic [2:0] f3;
  logic illegal, misal, oor, err;
  logic [31:0] sh, ld;
  assign f3 = REQ_FUNCT3;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR = err_q;
  always_comb begin
`ifdef LSU_SUBWORD_EN
    illegal = REQ_WRITE ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
`else
    illegal = f3 != 3'b010;
`endif
    misal = (f3[1:0] == 2'b10 && REQ_ADDR[1:0] != 2'b00) || (f3[1:0] == 2'b01 && REQ_ADDR[0]);
    oor = {2'b00, REQ_ADDR[31:2]} >= MEM_WORDS;
    err = illegal || misal || oor;
    sh = MEM_RD >> {REQ_ADDR[1:0], 3'b000};
    ld = f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
         f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
         f3 == 3'b100 ? {24'b0, sh[7:0]} :
         f3 == 3'b101 ? {16'b0, sh[15:0]} : sh;
  end
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d = err_q;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    MEM_WE = 1'b0;
    MEM_A = '0;
    MEM_WD = '0;
`ifdef LSU_SUBWORD_EN
    old_d = old_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    off_d = off_q;
    half_d = half_q;
    mask = (half_q ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
`endif
    if (state_q == IDLE) begin
      REQ_READY = 1'b1;
      MEM_A = {REQ_ADDR[31:2], 2'b00};
      if (REQ_VALID) begin
        state_d = RESP;
        err_d = err;
        rdata_d = (err || REQ_WRITE) ? '0 : ld;
        if (!err && REQ_WRITE) begin
`ifdef LSU_SUBWORD_EN
          if (f3[1:0] != 2'b10) begin
            state_d = RMW_WR;
            old_d = MEM_RD;
            waddr_d = REQ_ADDR[31:2];
            wdata_d = REQ_WDATA[15:0];
            off_d = REQ_ADDR[1:0];
            half_d = f3[0];
          end else
`endif
          begin
            MEM_WE = 1'b1;
            MEM_WD = REQ_WDATA;
          end
        end
      end
    end
`ifdef LSU_SUBWORD_EN
    else if (state_q == RMW_WR) begin
      MEM_A = {waddr_q, 2'b00};
      MEM_WE = 1'b1;
      MEM_WD = (old_q & ~mask) | (({16'b0, wdata_q} << {off_q, 3'b000}) & mask);
      state_d = RESP;
    end
`endif
    else begin
      RSP_VALID = 1'b1;
      if (RSP_READY) state_d = IDLE;
    end
    // memory outputs sit at zero while reset is held, whatever the request pins show
    if (!RST_N) begin
      MEM_WE = 1'b0;
      MEM_A = '0;
      MEM_WD = '0;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
`ifdef LSU_SUBWORD_EN
      old_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      off_q <= '0;
      half_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
`ifdef LSU_SUBWORD_EN
      old_q <= old_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      off_q <= off_d;
      half_q <= half_d;
`endif
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests checked against a byte-level memory model.
module tb_load_store_unit;
  localparam int MW = 11;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic CLK = 1'b0, RST_N = 1'b0, REQ_VALID = 1'b0, REQ_WRITE = 1'b0, RSP_READY = 1'b0;
  logic [2:0] REQ_FUNCT3 = '0;
  logic [31:0] REQ_ADDR = '0, REQ_WDATA = '0;
  logic REQ_READY, RSP_VALID, RSP_ERR, MEM_WE;
  logic [31:0] RSP_RDATA, MEM_A, MEM_WD, MEM_RD;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_a, last_wd;
  int tests = 0, fails = 0, we_cnt = 0;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE), .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .MEM_WE(MEM_WE), .MEM_A(MEM_A),
    .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;
  assign MEM_RD = (MEM_A[31:6] == 26'd0) ? mem[MEM_A[5:2]] : 32'h0;
  always @(posedge CLK) begin
    if (MEM_WE) begin
      we_cnt++;
      last_a = MEM_A;
      last_wd = MEM_WD;
      if (MEM_A[31:6] == 26'd0) mem[MEM_A[5:2]] <= MEM_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-granular view of memory, RV32I size/sign rules as plain arithmetic.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output bit e, output logic [31:0] rd, output int lat, output int we);
    int sz;
    bit legal;
    longint v;
    sz = (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
    if (SUB) legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else legal = (f3 == 3'd2);
    e = !legal || (a % sz != 0) || (a / 4 >= MW);
    rd = '0;
    lat = 1;
    we = 0;
    if (e) return;
    if (!w) begin
      v = (longint'(ref_mem[a / 4]) >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
      if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
      rd = 32'(v);
    end else begin
      we = 1;
      if (sz == 4) ref_mem[a / 4] = wd;
      else begin
        lat = 2;
        for (int i = 0; i < sz; i++) ref_mem[a / 4][8 * (a % 4 + i) +: 8] = wd[8 * i +: 8];
      end
    end
  endtask

  task automatic req(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int hold);
    bit e;
    logic [31:0] rd;
    int lat, elat, ewe;
    model(w, f3, a, wd, e, rd, elat, ewe);
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_WRITE = w;
    REQ_FUNCT3 = f3;
    REQ_ADDR = a;
    REQ_WDATA = wd;
    we_cnt = 0;
    chk("req_ready_idle", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 5) begin
      @(posedge CLK);
      #1 lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("rsp_err", 32'(RSP_ERR), 32'(e));
    chk("rsp_rdata", RSP_RDATA, rd);
    chk("we_count", 32'(we_cnt), 32'(ewe));
    if (ewe != 0) begin
      chk("mem_a", last_a, {a[31:2], 2'b00});
      chk("mem_wd", last_wd, ref_mem[a / 4]);
      chk("mem_word", mem[a / 4], ref_mem[a / 4]);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      chk("hold_valid_ready", {30'd0, RSP_VALID, REQ_READY}, 32'd2);
      chk("hold_rdata", RSP_RDATA, rd);
      chk("hold_err", 32'(RSP_ERR), 32'(e));
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("back_to_idle", {30'd0, RSP_VALID, REQ_READY}, 32'd1);
    chk("we_total", 32'(we_cnt), 32'(ewe));
    RSP_READY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    chk("rst_outputs", {28'd0, REQ_READY, RSP_VALID, RSP_ERR, MEM_WE}, 32'h8);
    chk("rst_rdata", RSP_RDATA, 32'h0);
    chk("rst_mem_a", MEM_A, 32'h0);
    chk("rst_mem_wd", MEM_WD, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0);
    req(1'b0, 3'b010, 32'h8, 32'h0, 0);
    req(1'b1, 3'b000, 32'h9, 32'h0000_0055, 0);
    req(1'b0, 3'b000, 32'h9, 32'h0, 0);
    req(1'b0, 3'b001, 32'hA, 32'h0, 0);
    req(1'b0, 3'b101, 32'hA, 32'h0, 0);
    req(1'b0, 3'b010, 32'h6, 32'h0, 0);
    req(1'b1, 3'b001, 32'h3, 32'h1234_5678, 0);
    req(1'b0, 3'b010, 32'h2C, 32'h0, 0);
    req(1'b0, 3'b010, 32'h28, 32'h0, 0);
    req(1'b0, 3'b010, 32'h8, 32'h0, 5);
    req(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, 0);
    req(1'b0, 3'b110, 32'h10, 32'h0, 0);
    // reset arrives one cycle into a sub-word store: nothing may reach memory
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_WRITE = 1'b1;
    REQ_FUNCT3 = 3'b000;
    REQ_ADDR = 32'h4;
    REQ_WDATA = 32'hA5;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_outputs", {28'd0, REQ_READY, RSP_VALID, RSP_ERR, MEM_WE}, 32'h8);
    chk("midrst_rdata", RSP_RDATA, 32'h0);
    chk("midrst_mem_a", MEM_A, 32'h0);
    chk("midrst_mem_wd", MEM_WD, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_word", mem[1], ref_mem[1]);
    for (int n = 0; n < 60; n++)
      req(1'($urandom), 3'($urandom), 32'($urandom_range(0, 13) * 4 + $urandom_range(0, 3)), $urandom,
          int'($urandom_range(0, 2)));
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
